// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified-memory port arbiter: FSM states and
// transaction owner identifiers.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises IF (instruction) and MEM (data) stage accesses onto one single-ported
// memory with a fixed access latency; data port wins unless the fetch port is starving.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = 16,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam int STRK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_LIMIT);

  arb_state_e             state_q, state_d;
  owner_e                 owner_q;
  logic [CNT_W-1:0]       count_q;
  logic [STRK_W-1:0]      streak_q;
  logic [WORD_SIZE-1:0]   addr_q;
  logic                   we_q;
  logic [WORD_SIZE-1:0]   wdata_q;
  logic [WORD_SIZE-1:0]   i_rdata_q;
  logic [WORD_SIZE-1:0]   d_rdata_q;

  logic any_req;
  logic arb_window;
  logic do_grant;
  logic grant_i;
  logic grant_d;

  function automatic logic [STRK_W-1:0] streak_sat_inc(input logic [STRK_W-1:0] v);
    return (v == STRK_MAX) ? v : v + 1'b1;
  endfunction

  // Arbitration is only evaluated on the edge that leaves IDLE or RESP.
  assign any_req    = i_req | d_req;
  assign arb_window = (state_q == ARB_IDLE) || (state_q == ARB_RESP);
  assign do_grant   = arb_window && any_req;
  assign grant_i    = i_req && (!d_req || (streak_q == STRK_MAX));
  assign grant_d    = d_req && !grant_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_BUSY;
      ARB_BUSY: if (count_q == '0) state_d = ARB_RESP;
      ARB_RESP: state_d = any_req ? ARB_BUSY : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == ARB_BUSY);
    mem_read  = busy && !we_q;
    mem_write = busy && we_q;
    i_ready   = (state_q == ARB_RESP) && (owner_q == OWNER_I);
    d_ready   = (state_q == ARB_RESP) && (owner_q == OWNER_D);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
  end

  // Transaction latch: the memory side only ever sees these registered copies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWNER_NONE;
      count_q   <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (do_grant) begin
      owner_q <= grant_d ? OWNER_D : OWNER_I;
      addr_q  <= grant_d ? d_addr : i_addr;
      we_q    <= grant_d && d_we;
      wdata_q <= grant_d ? d_wdata : '0;
      count_q <= CNT_INIT;
    end else if (state_q == ARB_BUSY) begin
      if (count_q == '0) begin
        if (!we_q && (owner_q == OWNER_I)) i_rdata_q <= mem_rdata;
        if (!we_q && (owner_q == OWNER_D)) d_rdata_q <= mem_rdata;
      end else begin
        count_q <= count_q - 1'b1;
      end
    end else if (state_q == ARB_RESP) begin
      owner_q <= OWNER_NONE;
    end
  end

  // Counts data grants taken while a fetch was waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
    end else if (do_grant) begin
      if (grant_i || !i_req) begin
        streak_q <= '0;
      end else begin
        streak_q <= streak_sat_inc(streak_q);
      end
    end
  end

endmodule
